// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, clocks-per-bit
// helper and parameter legality check (also intended for uart_tx_param).
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_rx_state_e;

   localparam int MIN_BPS_CNT = 8;

   function automatic int bps_cnt(input int clk_hz, input int bps);
      return clk_hz / bps;
   endfunction

   function automatic bit uart_params_ok(input int clk_hz, input int bps,
                                         input int data_bits, input int stop_bits,
                                         input int parity_odd);
      if (bps <= 0) return 1'b0;
      if (bps_cnt(clk_hz, bps) < MIN_BPS_CNT) return 1'b0;
      if (data_bits < 5 || data_bits > 9) return 1'b0;
      if (stop_bits < 1 || stop_bits > 2) return 1'b0;
      if (parity_odd < 0 || parity_odd > 1) return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX line conditioning: 2-flop synchroniser (idles high), 3-tap history
// with majority vote, and falling-edge detect on the synchronised line.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx_pin,
   output logic rx_bit,
   output logic rx_fall
);

   logic [1:0] sync_q, sync_d;
   logic [2:0] hist_q, hist_d;

   // shift the raw pin through the synchroniser and the history register
   always_comb begin
      sync_d = {sync_q[0], rx_pin};
      hist_d = {hist_q[1:0], sync_q[1]};
   end

   // reset to idle-high so release never looks like a start edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '1;
         hist_q <= '1;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign rx_bit  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
   assign rx_fall = hist_q[0] & ~sync_q[1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready holding register.
// Optional parity check compiled in with `define UART_RX_PARITY_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a falling edge
// ST_START  | timing half a bit to re-check the start bit (glitch reject)
// ST_DATA   | sampling DATA_BITS at bit centres, LSB first
// ST_PARITY | sampling the parity bit (parity builds only)
// ST_STOP   | sampling STOP_BITS; frame completes on the last one
import uart_pkg::*;

module uart_rx_param #(
   parameter int CLK        = 200_000_000,
   parameter int BPS        = 115200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_pin,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam int BPS_CNT = bps_cnt(CLK, BPS);
   localparam int CNT_W   = $clog2(BPS_CNT);
   localparam int BIT_W   = $clog2(DATA_BITS + 1);

   // timers count down to zero; first wait is half a bit, then whole bits
   localparam logic [CNT_W-1:0] HALF_LD   = CNT_W'(BPS_CNT / 2);
   localparam logic [CNT_W-1:0] FULL_LD   = CNT_W'(BPS_CNT - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   generate
      if (!uart_params_ok(CLK, BPS, DATA_BITS, STOP_BITS, PARITY_ODD)) begin : g_param_err
         $error("uart_rx_param: illegal parameter combination");
      end
   endgenerate

   logic                 rx_bit, rx_fall;
   uart_rx_state_e       state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 fe_acc_q, fe_acc_d;
   logic                 frame_done, frame_fe;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
   localparam logic ODD_BIT = (PARITY_ODD != 0);
   logic                 pe_acc_q, pe_acc_d;
   logic                 frame_pe;
   logic                 parity_err_q, parity_err_d;
`endif

   uart_rx_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .rx_pin (rx_pin),
      .rx_bit (rx_bit),
      .rx_fall(rx_fall)
   );

   // frame FSM: next state, bit timers, data shifter and error accumulation
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      fe_acc_d   = fe_acc_q;
      frame_done = 1'b0;
      frame_fe   = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_acc_d   = pe_acc_q;
      frame_pe   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d     = HALF_LD;
            bit_cnt_d = '0;
            fe_acc_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_acc_d  = 1'b0;
`endif
            if (rx_fall) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == '0) begin
               cnt_d = FULL_LD;
               if (rx_bit) state_d = ST_IDLE;
               else        state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == '0) begin
               cnt_d   = FULL_LD;
               shift_d = {rx_bit, shift_q[DATA_BITS-1:1]};
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt_q == '0) begin
               cnt_d    = FULL_LD;
               pe_acc_d = rx_bit ^ (^shift_q) ^ ODD_BIT;
               state_d  = ST_STOP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_q == '0) begin
               cnt_d = FULL_LD;
               if (!rx_bit) fe_acc_d = 1'b1;
               if (bit_cnt_q == STOP_LAST) begin
                  // no trailing idle needed: IDLE can catch the next start edge
                  state_d    = ST_IDLE;
                  frame_done = 1'b1;
                  frame_fe   = fe_acc_q | ~rx_bit;
`ifdef UART_RX_PARITY_EN
                  frame_pe   = pe_acc_q;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // holding register: load on completion when free or being drained, else overrun
   always_comb begin
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = frame_err_q;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = parity_err_q;
`endif
      if (valid_q && rx_ready) valid_d = 1'b0;
      if (frame_done) begin
         if (!valid_q || rx_ready) begin
            data_d      = shift_q;
            valid_d     = 1'b1;
            frame_err_d = frame_fe;
`ifdef UART_RX_PARITY_EN
            parity_err_d = frame_pe;
`endif
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         fe_acc_q    <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pe_acc_q     <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         fe_acc_q    <= fe_acc_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
         pe_acc_q     <= pe_acc_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign rx_busy   = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at 10 clocks per bit, 8 data bits, 1 stop.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_param;

   localparam int BIT_CLKS = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_pin = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, parity_err, overrun, rx_busy;

   int tests = 0;
   int fails = 0;

   int         valid_cycles = 0;
   int         overrun_pulses = 0;
   logic [7:0] cap_data = 8'h00;
   logic       cap_fe = 1'b0;
   logic       cap_pe = 1'b0;

   uart_rx_param #(
      .CLK       (50_000_000),
      .BPS       (5_000_000),
      .DATA_BITS (8),
      .STOP_BITS (1),
      .PARITY_ODD(0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_pin    (rx_pin),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .parity_err(parity_err),
      .overrun   (overrun),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   // record what the holding register presents, away from the active edge
   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cycles <= valid_cycles + 1;
         cap_data     <= rx_data;
         cap_fe       <= frame_err;
         cap_pe       <= parity_err;
      end
      if (overrun) overrun_pulses <= overrun_pulses + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx_pin = b;
      tick(BIT_CLKS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par_v);
`endif
      send_bit(stop_v);
      rx_pin = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      rx_pin = 1'b1;
      rx_ready = 1'b1;
      tick(3);
      tests++;
      if ({rx_data, rx_valid, frame_err, parity_err, overrun, rx_busy} !== 13'h0) begin
         fails++;
         $display("FAIL reset_outputs: got %h expected 0", {rx_data, rx_valid, frame_err, parity_err, overrun, rx_busy});
      end
      rst = 1'b1;
      tick(5);
      tests++;
      if ({rx_valid, rx_busy} !== 2'b00) begin
         fails++;
         $display("FAIL reset_release_idle: valid/busy got %b expected 00", {rx_valid, rx_busy});
      end
   endtask

   task automatic test_basic();
      int v0;
      v0 = valid_cycles;
      rx_ready = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b0);
      tick(3);
      tests++;
      if (valid_cycles - v0 !== 1) begin
         fails++;
         $display("FAIL basic_valid_cycles: got %0d expected 1", valid_cycles - v0);
      end
      tests++;
      if (cap_data !== 8'hA5) begin
         fails++;
         $display("FAIL basic_data: got %h expected a5", cap_data);
      end
      tests++;
      if ({cap_fe, cap_pe} !== 2'b00) begin
         fails++;
         $display("FAIL basic_flags: fe/pe got %b expected 00", {cap_fe, cap_pe});
      end
      tests++;
      if (rx_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_valid_drop: got %b expected 0", rx_valid);
      end
   endtask

   task automatic test_patterns();
      logic [7:0] pats [4];
      logic [7:0] pars [4];
      int v0;
      pats = '{8'h00, 8'hFF, 8'h80, 8'h3A};
      pars = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 4; k++) begin
         v0 = valid_cycles;
         send_frame(pats[k], 1'b1, pars[k][0]);
         tick(3);
         tests++;
         if (valid_cycles - v0 !== 1 || cap_data !== pats[k] || cap_fe !== 1'b0 || cap_pe !== 1'b0) begin
            fails++;
            $display("FAIL pattern_%0d: got data %h fe %b pe %b cycles %0d expected data %h fe 0 pe 0 cycles 1",
                     k, cap_data, cap_fe, cap_pe, valid_cycles - v0, pats[k]);
         end
      end
   endtask

   task automatic test_glitch();
      int v0;
      int n;
      v0 = valid_cycles;
      rx_pin = 1'b0;
      tick(3);
      rx_pin = 1'b1;
      tests++;
      if (rx_busy !== 1'b1) begin
         fails++;
         $display("FAIL glitch_busy_rise: got %b expected 1", rx_busy);
      end
      n = 0;
      while (rx_busy === 1'b1 && n < 12) begin
         tick(1);
         n++;
      end
      tests++;
      if (rx_busy !== 1'b0 || n > 6) begin
         fails++;
         $display("FAIL glitch_busy_fall: busy %b after %0d clk, required 0 within 6", rx_busy, n);
      end
      tick(2 * BIT_CLKS);
      tests++;
      if (valid_cycles - v0 !== 0) begin
         fails++;
         $display("FAIL glitch_no_frame: valid cycles got %0d expected 0", valid_cycles - v0);
      end
   endtask

   task automatic test_frame_err();
      int v0;
      v0 = valid_cycles;
      send_frame(8'h3C, 1'b0, 1'b0);
      tick(BIT_CLKS);
      tests++;
      if (valid_cycles - v0 !== 1 || cap_data !== 8'h3C) begin
         fails++;
         $display("FAIL ferr_data: got %h cycles %0d expected 3c cycles 1", cap_data, valid_cycles - v0);
      end
      tests++;
      if (cap_fe !== 1'b1) begin
         fails++;
         $display("FAIL ferr_flag: got %b expected 1", cap_fe);
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      send_frame(8'h01, 1'b1, 1'b0);
      tick(3);
      tests++;
      if (cap_data !== 8'h01 || cap_pe !== 1'b1) begin
         fails++;
         $display("FAIL parity_bad: data %h pe %b expected data 01 pe 1", cap_data, cap_pe);
      end
      send_frame(8'h01, 1'b1, 1'b1);
      tick(3);
      tests++;
      if (cap_data !== 8'h01 || cap_pe !== 1'b0) begin
         fails++;
         $display("FAIL parity_good: data %h pe %b expected data 01 pe 0", cap_data, cap_pe);
      end
   endtask
`endif

   task automatic test_overrun();
      int o0;
      o0 = overrun_pulses;
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0);
      tests++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h11 || overrun_pulses - o0 !== 0) begin
         fails++;
         $display("FAIL ovr_first: valid %b data %h pulses %0d expected 1 11 0", rx_valid, rx_data, overrun_pulses - o0);
      end
      send_frame(8'h22, 1'b1, 1'b0);
      tick(3);
      tests++;
      if (overrun_pulses - o0 !== 1) begin
         fails++;
         $display("FAIL ovr_pulse: pulses got %0d expected 1", overrun_pulses - o0);
      end
      tests++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
         fails++;
         $display("FAIL ovr_hold: valid %b data %h expected 1 11", rx_valid, rx_data);
      end
      rx_ready = 1'b1;
      tick(1);
      tests++;
      if (rx_valid !== 1'b0) begin
         fails++;
         $display("FAIL ovr_drain: valid got %b expected 0", rx_valid);
      end
   endtask

   task automatic test_reset_midframe();
      int v0;
      rx_ready = 1'b0;
      send_frame(8'h77, 1'b1, 1'b1);
      tick(2);
      tests++;
      if (rx_valid !== 1'b1) begin
         fails++;
         $display("FAIL midrst_pre_valid: got %b expected 1", rx_valid);
      end
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rx_pin = 1'b1;
      tick(4);
      tests++;
      if (rx_busy !== 1'b1) begin
         fails++;
         $display("FAIL midrst_pre_busy: got %b expected 1", rx_busy);
      end
      rst = 1'b0;
      #1;
      tests++;
      if ({rx_data, rx_valid, frame_err, parity_err, overrun, rx_busy} !== 13'h0) begin
         fails++;
         $display("FAIL midrst_outputs: got %h expected 0", {rx_data, rx_valid, frame_err, parity_err, overrun, rx_busy});
      end
      tick(3);
      rst = 1'b1;
      tick(5);
      rx_ready = 1'b1;
      v0 = valid_cycles;
      send_frame(8'h5A, 1'b1, 1'b0);
      tick(3);
      tests++;
      if (valid_cycles - v0 !== 1 || cap_data !== 8'h5A || cap_fe !== 1'b0 || cap_pe !== 1'b0) begin
         fails++;
         $display("FAIL midrst_after: data %h fe %b pe %b cycles %0d expected 5a 0 0 1",
                  cap_data, cap_fe, cap_pe, valid_cycles - v0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_patterns();
      test_glitch();
      test_frame_err();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_overrun();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: oversampled start-bit validation, majority-vote bit sampling, configurable data/stop bits, optional parity check, and a valid/ready output holding register with error and overrun reporting. Sits between the FPGA RX pin and any byte-stream consumer (command parser, FIFO), replacing the fixed 8N1 receiver where back-pressure or error visibility is needed.

## Interface
- CLK, 200_000_000, system clock frequency in Hz
- BPS, 115200, baud rate; BPS_CNT = CLK/BPS clocks per bit (must be >= 8)
- DATA_BITS, 8, data bits per frame, legal 5..9
- STOP_BITS, 1, stop bits checked, legal 1 or 2
- PARITY_ODD, 0, parity sense when parity compiled in: 0 even, 1 odd
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rx_pin  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_BITS  received word, LSB first on the line
- rx_valid  output  1  rx_data/error flags hold a frame
- rx_ready  input  1  consumer accepts frame when high with rx_valid
- frame_err  output  1  stop bit(s) sampled low for held frame
- parity_err  output  1  parity mismatch for held frame (0 when parity compiled out)
- overrun  output  1  one-cycle pulse: completed frame dropped
- rx_busy  output  1  FSM not in IDLE

## Operation
- rx_pin passes a 2-flop synchroniser (reset value 1) then a 3-bit history shift register; sampled bit = majority of the 3 most recent synchronised values.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: falling edge on synchronised line -> START, bit counter cleared.
- START: at clk_cnt == BPS_CNT/2 take majority; 1 -> IDLE (glitch rejected, nothing reported); 0 -> DATA, clk_cnt restarts so all later samples fall at bit centres (BPS_CNT spacing).
- DATA: DATA_BITS samples shifted in LSB first; then PARITY if compiled in, else STOP.
- PARITY: sample compared with XOR of data (inverted if PARITY_ODD).
- STOP: STOP_BITS samples; any 0 sets frame error. After last stop sample -> IDLE immediately (back-to-back frames need no extra idle).
- Completion: if holding register empty, or rx_valid && rx_ready in same cycle, load rx_data/frame_err/parity_err, rx_valid=1. Otherwise frame discarded, holding register untouched, overrun pulses.
- Frames with errors are still delivered, with flags set.
- rx_valid clears on the edge where rx_valid && rx_ready, unless a new frame loads in that same cycle (stays 1, new data).

## Timing
- Reset (any time, including mid-frame): FSM IDLE, counters 0, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, overrun 0, rx_busy 0, synchroniser 1. After release a new frame needs a fresh falling edge.
- Start detect: 2-3 clk after rx_pin falls.
- rx_valid rises 1 clk after final stop-bit centre sample.
- overrun high exactly 1 clk, same cycle rx_valid would have loaded.
- clk counter width $clog2(BPS_CNT); bit counter width $clog2(DATA_BITS+1).
- rx_busy high from START entry until return to IDLE.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state present, parity_err driven per PARITY_ODD, frame length 1+DATA_BITS+1+STOP_BITS.
- Undefined: no PARITY state, parity_err tied 0, frame length 1+DATA_BITS+STOP_BITS; PARITY_ODD ignored.

## Structure
- Package uart_pkg: FSM state enum, bps_cnt(CLK,BPS) function, parameter legality checks shared with a future uart_tx_param.
- Sub-module uart_rx_sync: 2-flop synchroniser + 3-tap majority + falling-edge detect; FSM, counters and holding register stay in top.

## Test plan
Bench uses CLK=50_000_000, BPS=5_000_000 (BPS_CNT=10).
- 8N1 frame 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid 1 cycle, frame_err=0, parity_err=0.
- rx_pin low for 3 clk then high -> no rx_valid, rx_busy returns 0 within 6 clk.
- Frame 0x3C with stop bit driven 0 -> rx_data=0x3C, frame_err=1.
- UART_RX_PARITY_EN, PARITY_ODD=0, 0x01 sent with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
- rx_ready=0, frames 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun pulses once at 0x22 completion; raise rx_ready -> rx_valid drops next edge.
- Assert rst during data bit 4 of 0xFF -> all outputs 0 immediately; release, send 0x5A -> rx_data=0x5A, no errors.
